// File: rtl/button_event_decoder_if.sv
// Bundles the debounced button level with the decoded UI event outputs.
// Purely combinational wiring; no latency of its own.
// No backpressure: every event is a one-cycle pulse the consumer must take.
interface button_event_decoder_if;
    logic debouncedSignal;
    logic pressPulse;
    logic releasePulse;
    logic shortClick;
    logic longPress;
    logic repeatPulse;
    logic heldLevel;
    logic doubleClick;

    // Producer of the button level / consumer of the events (upstream/downstream logic)
    modport master (
        output debouncedSignal,
        input  pressPulse,
        input  releasePulse,
        input  shortClick,
        input  longPress,
        input  repeatPulse,
        input  heldLevel,
        input  doubleClick
    );

    // The decoder itself
    modport slave (
        input  debouncedSignal,
        output pressPulse,
        output releasePulse,
        output shortClick,
        output longPress,
        output repeatPulse,
        output heldLevel,
        output doubleClick
    );
endinterface

// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into press/release/click/long/repeat(/double-click) pulses.
// Latency: every pulse appears 1 cycle after the clock edge evaluating its condition; heldLevel follows state.
// No backpressure: events are fire-and-forget pulses. Optional macro DOUBLE_CLICK_EN adds double-click detection.
module button_event_decoder #(
    parameter int CNT_W        = 24,
    parameter int LONG_TICKS   = 12500000,
    parameter int REPEAT_TICKS = 2500000,
    parameter int DCLICK_TICKS = 7500000
) (
    input  logic                    clk,
    input  logic                    resetN,
    button_event_decoder_if.slave   bus
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

`ifdef DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESSED  = 3'd1,
        HELD     = 3'd2,
        WAIT2    = 3'd3,
        PRESSED2 = 3'd4
    } state_t;
`else
    // The double-click window is meaningless without the feature; keep it referenced.
    logic unused_dclick;
    assign unused_dclick = ^DCLICK_TICKS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESSED = 3'd1,
        HELD    = 3'd2
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             dclick_q, dclick_d;

    logic             rise;
    logic             fall;
    logic             counting;

    // A level already high out of reset looks like a rise because prev_q resets to 0.
    assign rise = bus.debouncedSignal & ~prev_q;
    assign fall = ~bus.debouncedSignal & prev_q;

    // State, counter, edge history and registered event pulses
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            dclick_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= bus.debouncedSignal;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            dclick_q  <= dclick_d;
        end
    end

    // Next state and tick counter; a release always beats a coincident threshold
    always_comb begin
        state_d  = state_q;
        counting = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESSED;
            end
            PRESSED: begin
                counting = 1'b1;
`ifdef DOUBLE_CLICK_EN
                if (fall)                    state_d = WAIT2;
`else
                if (fall)                    state_d = IDLE;
`endif
                else if (cnt_q == LONG_LAST) state_d = HELD;
            end
            HELD: begin
                counting = 1'b1;
                if (fall) state_d = IDLE;
            end
`ifdef DOUBLE_CLICK_EN
            WAIT2: begin
                counting = 1'b1;
                if (rise)                      state_d = PRESSED2;
                else if (cnt_q == DCLICK_LAST) state_d = IDLE;
            end
            PRESSED2: begin
                counting = 1'b1;
                if (fall)                    state_d = IDLE;
                else if (cnt_q == LONG_LAST) state_d = HELD;
            end
`endif
            default: state_d = IDLE;
        endcase

        if ((state_d != state_q) || repeat_d) cnt_d = '0;
        else if (counting)                    cnt_d = cnt_q + CNT_W'(1);
        else                                  cnt_d = cnt_q;
    end

    // Event conditions, registered next edge so every pulse is glitch-free
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        dclick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                press_d = rise;
            end
            PRESSED: begin
                release_d = fall;
`ifndef DOUBLE_CLICK_EN
                short_d   = fall;
`endif
                long_d    = ~fall & (cnt_q == LONG_LAST);
            end
            HELD: begin
                release_d = fall;
                repeat_d  = ~fall & (cnt_q == REPEAT_LAST);
            end
`ifdef DOUBLE_CLICK_EN
            WAIT2: begin
                press_d = rise;
                short_d = ~rise & (cnt_q == DCLICK_LAST);
            end
            PRESSED2: begin
                release_d = fall;
                dclick_d  = fall;
                // Reaching long-press here also reports the first click that was held back.
                long_d    = ~fall & (cnt_q == LONG_LAST);
                short_d   = ~fall & (cnt_q == LONG_LAST);
            end
`endif
            default: ;
        endcase
    end

    assign bus.pressPulse   = press_q;
    assign bus.releasePulse = release_q;
    assign bus.shortClick   = short_q;
    assign bus.longPress    = long_q;
    assign bus.repeatPulse  = repeat_q;
    assign bus.doubleClick  = dclick_q;
    assign bus.heldLevel    = (state_q == HELD);

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with small tick thresholds.
// Expected events are queued by the stimulus; a negedge monitor pops and compares.
// Optional DOUBLE_CLICK_EN scenarios are compiled only when the macro is defined.
module tb_button_event_decoder;

    localparam int LONG_T   = 8;
    localparam int REPEAT_T = 4;
    localparam int DCLICK_T = 6;

    // Event bit positions: {press, release, short, long, repeat, double}
    localparam logic [5:0] EV_P  = 6'b100000;
    localparam logic [5:0] EV_R  = 6'b010000;
    localparam logic [5:0] EV_S  = 6'b001000;
    localparam logic [5:0] EV_L  = 6'b000100;
    localparam logic [5:0] EV_RP = 6'b000010;
    localparam logic [5:0] EV_D  = 6'b000001;

    typedef struct {
        int         cyc;
        logic [5:0] ev;
        logic       held;
    } exp_t;

    logic clk = 1'b0;
    logic resetN;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    button_event_decoder_if bus();

    button_event_decoder #(
        .CNT_W        (8),
        .LONG_TICKS   (LONG_T),
        .REPEAT_TICKS (REPEAT_T),
        .DCLICK_TICKS (DCLICK_T)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [5:0] ev_now;
    assign ev_now = {bus.pressPulse, bus.releasePulse, bus.shortClick,
                     bus.longPress, bus.repeatPulse, bus.doubleClick};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int c, input logic [5:0] e, input logic h);
        exp_t x;
        x.cyc = c; x.ev = e; x.held = h;
        q.push_back(x);
    endtask

    // A short release: immediate click, or delayed by the double-click window.
    task automatic expect_short_release(input int c);
`ifdef DOUBLE_CLICK_EN
        expect_ev(c, EV_R, 1'b0);
        expect_ev(c + DCLICK_T, EV_S, 1'b0);
`else
        expect_ev(c, EV_R | EV_S, 1'b0);
`endif
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: level high for n sampled edges, then low for g edges.
    task automatic press(input int n, input int g);
        bus.debouncedSignal = 1'b1;
        wait_neg(n);
        bus.debouncedSignal = 1'b0;
        wait_neg(g);
    endtask

    // Monitor: every cycle with any pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (|ev_now) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {32'(cyc), 24'd0, 1'b0, ev_now, bus.heldLevel}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event", {32'(cyc), 24'd0, 1'b0, ev_now, bus.heldLevel},
                             {32'(e.cyc), 24'd0, 1'b0, e.ev, e.held});
            end
        end
    end

    initial begin
        int c0;
        resetN = 1'b0;
        bus.debouncedSignal = 1'b1;
        wait_neg(2);
        chk("reset_outputs", {57'd0, ev_now, bus.heldLevel}, 64'd0);

        // Level already high when reset lifts: counts as a fresh press.
        resetN = 1'b1;
        c0 = cyc + 1;
        expect_ev(c0, EV_P, 1'b0);
        expect_short_release(c0 + 2);
        wait_neg(2);
        bus.debouncedSignal = 1'b0;
        wait_neg(14);

        // Short press of 3 cycles.
        c0 = cyc + 1;
        expect_ev(c0, EV_P, 1'b0);
        expect_short_release(c0 + 3);
        press(3, 14);

        // Long hold with auto-repeat; the release lands on a repeat threshold.
        c0 = cyc + 1;
        expect_ev(c0,      EV_P,  1'b0);
        expect_ev(c0 + 8,  EV_L,  1'b1);
        expect_ev(c0 + 12, EV_RP, 1'b1);
        expect_ev(c0 + 16, EV_RP, 1'b1);
        expect_ev(c0 + 20, EV_R,  1'b0);
        press(20, 2);
        chk("held_after_release", {63'd0, bus.heldLevel}, 64'd0);
        wait_neg(12);

        // Release exactly on the long-press threshold: click wins.
        c0 = cyc + 1;
        expect_ev(c0, EV_P, 1'b0);
        expect_short_release(c0 + 8);
        press(8, 14);

`ifdef DOUBLE_CLICK_EN
        // Two 2-cycle presses, 3 cycles apart.
        c0 = cyc + 1;
        expect_ev(c0,     EV_P,        1'b0);
        expect_ev(c0 + 2, EV_R,        1'b0);
        expect_ev(c0 + 5, EV_P,        1'b0);
        expect_ev(c0 + 7, EV_R | EV_D, 1'b0);
        press(2, 3);
        press(2, 14);

        // Single press, then the window expires.
        c0 = cyc + 1;
        expect_ev(c0, EV_P, 1'b0);
        expect_short_release(c0 + 2);
        press(2, 14);

        // Reset while waiting for a second press: the pending click is dropped.
        c0 = cyc + 1;
        expect_ev(c0,     EV_P, 1'b0);
        expect_ev(c0 + 2, EV_R, 1'b0);
        press(2, 2);
        resetN = 1'b0;
        wait_neg(2);
        chk("reset_in_wait2", {57'd0, ev_now, bus.heldLevel}, 64'd0);
        resetN = 1'b1;
        wait_neg(12);

        // Back in IDLE: a normal press behaves normally.
        c0 = cyc + 1;
        expect_ev(c0, EV_P, 1'b0);
        expect_short_release(c0 + 3);
        press(3, 14);
`endif

        wait_neg(4);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
